// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the RV32M multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] result;
  logic            done;
  logic            busy;
  logic            stall;

  modport master (
    output start, flush, op, src_a, src_b,
    input  result, done, busy, stall
  );

  modport slave (
    input  start, flush, op, src_a, src_b,
    output result, done, busy, stall
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_MUL_1CYC_EN: multiplies complete through a single-cycle combinational product.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);
  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [2:0]      op_q;
  logic [XLEN-1:0] opnd;
  logic [PW-1:0]   acc;
  logic            neg_q;
  logic            neg_r;
  logic            div_zero;
  logic [XLEN-1:0] result_q;
  logic            done_q;
  logic            busy_q;

  logic            sgn_a_c, sgn_b_c;
  logic [XLEN-1:0] mag_a_c, mag_b_c;
  logic [PW-1:0]   acc_next;
  logic [XLEN:0]   trial;
  logic [XLEN:0]   sum;
  logic [XLEN-1:0] diff;
  logic [PW-1:0]   prod;
  logic [XLEN-1:0] fin_val;

  // Operand sign flags and magnitudes for the incoming request
  always_comb begin
    sgn_a_c = bus.src_a[XLEN-1] && (bus.op inside {3'd1, 3'd2, 3'd4, 3'd6});
    sgn_b_c = bus.src_b[XLEN-1] && (bus.op inside {3'd1, 3'd4, 3'd6});
    mag_a_c = sgn_a_c ? (~bus.src_a + XLEN'(1)) : bus.src_a;
    mag_b_c = sgn_b_c ? (~bus.src_b + XLEN'(1)) : bus.src_b;
  end

  // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    acc_next = acc;
    trial    = '0;
    sum      = '0;
    diff     = '0;
    if (op_q[2]) begin
      trial = acc[PW-1:XLEN-1];
      if (trial >= {1'b0, opnd}) begin
        diff     = XLEN'(trial - {1'b0, opnd});
        acc_next = {diff, acc[XLEN-2:0], 1'b1};
      end else begin
        acc_next = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end
    end else begin
      sum      = {1'b0, acc[PW-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

  // Sign correction and result selection applied to the final iteration
  always_comb begin
    prod    = neg_q ? (~acc_next + PW'(1)) : acc_next;
    fin_val = (op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
    if (op_q[2]) begin
      if (op_q[1])
        fin_val = neg_r ? (~acc_next[PW-1:XLEN] + XLEN'(1)) : acc_next[PW-1:XLEN];
      else if (div_zero)
        fin_val = '1;
      else
        fin_val = neg_q ? (~acc_next[XLEN-1:0] + XLEN'(1)) : acc_next[XLEN-1:0];
    end
  end

`ifdef MULDIV_MUL_1CYC_EN
  logic [PW-1:0]   fast_prod;
  logic [XLEN-1:0] fast_val;

  always_comb begin
    fast_prod = PW'(mag_a_c) * PW'(mag_b_c);
    if (sgn_a_c ^ sgn_b_c)
      fast_prod = ~fast_prod + PW'(1);
    fast_val = (bus.op[1:0] == 2'd0) ? fast_prod[XLEN-1:0] : fast_prod[PW-1:XLEN];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      op_q     <= '0;
      opnd     <= '0;
      acc      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else if (bus.flush) begin
      state  <= IDLE;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q     <= bus.op;
            count    <= '0;
            neg_q    <= sgn_a_c ^ sgn_b_c;
            neg_r    <= sgn_a_c;
            div_zero <= (bus.src_b == '0);
            opnd     <= bus.op[2] ? mag_b_c : mag_a_c;
            acc      <= {{XLEN{1'b0}}, (bus.op[2] ? mag_a_c : mag_b_c)};
            busy_q   <= 1'b1;
`ifdef MULDIV_MUL_1CYC_EN
            if (!bus.op[2]) begin
              state    <= DONE;
              result_q <= fast_val;
              done_q   <= 1'b1;
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          acc   <= acc_next;
          count <= count + CW'(1);
          if (count == CW'(XLEN - 1)) begin
            state    <= DONE;
            result_q <= fin_val;
            done_q   <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.stall  = ((state == IDLE) && bus.start && !bus.flush) || (state == CALC);
endmodule
